// File: rtl/adc_joystick_bargraph.sv
// Joystick axis to centred LED bargraph.
// Self-calibrating centre, dead-band, stepped levels, hysteresis.
module adc_joystick_bargraph #(
  parameter int ADC_W    = 12,
  parameter int N_LED    = 8,
  parameter int AVG_LOG2 = 3,
  parameter int DEADBAND = 125,
  parameter int STEP     = 500,
  parameter int HYST     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adc_valid,
  input  logic [ADC_W-1:0]              adc_data,
  input  logic                          cal_start,
  output logic [N_LED-1:0]              led_out,
  output logic [ADC_W-1:0]              center,
  output logic                          cal_busy,
  output logic [$clog2(N_LED/2+1):0]    level
);

  localparam int HALF = N_LED / 2;
  localparam int CW   = $clog2(HALF + 1);
  localparam int LW   = CW + 1;
  localparam int AW   = ADC_W + AVG_LOG2;

  localparam logic [N_LED-1:0] NEUTRAL =
    {{(HALF-1){1'b0}}, 2'b11, {(HALF-1){1'b0}}};

  localparam logic [ADC_W-1:0] MID =
    ADC_W'(1) << (ADC_W - 1);

  typedef enum logic {
    S_CAL,
    S_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [AVG_LOG2-1:0]  cnt_q, cnt_d;
  logic [ADC_W-1:0]     center_q, center_d;
  logic [N_LED-1:0]     led_q, led_d;
  logic                 busy_q, busy_d;
  logic signed [LW-1:0] level_q, level_d;

  logic [AW-1:0]        sum;
  logic [ADC_W:0]       diff;
  logic                 dir_neg;
  logic [ADC_W-1:0]     mag;
  logic [31:0]          mag_w;
  logic [31:0]          thr;
  logic [31:0]          thr_h;
  logic [CW-1:0]        lup;
  logic [CW-1:0]        ldn;
  logic                 cur_neg;
  logic [CW-1:0]        cur_mag;
  logic                 same_dir;
  logic [CW-1:0]        hold;
  logic [CW-1:0]        nmag;
  logic                 nneg;
  logic signed [LW-1:0] new_lvl;
  logic [N_LED-1:0]     pat;

  assign sum = acc_q + AW'(adc_data);

  // Deflection from centre and how many thresholds it clears.
  always_comb begin
    diff    = {1'b0, adc_data} - {1'b0, center_q};
    dir_neg = diff[ADC_W];
    mag     = dir_neg ? ADC_W'(-diff) : diff[ADC_W-1:0];
    mag_w   = 32'(mag);
    thr     = '0;
    thr_h   = '0;
    lup     = '0;
    ldn     = '0;
    for (int k = 1; k <= HALF; k++) begin
      thr   = 32'(DEADBAND) + 32'(k - 1) * 32'(STEP);
      thr_h = (thr > 32'(HYST)) ? thr - 32'(HYST) : '0;
      if (mag_w > thr)   lup = lup + CW'(1);
      if (mag_w > thr_h) ldn = ldn + CW'(1);
    end
  end

  // Next level with hysteresis on falls, plus its LED pattern.
  always_comb begin
    cur_neg  = level_q[LW-1];
    cur_mag  = cur_neg ? CW'(-level_q) : CW'(level_q);
    same_dir = (cur_mag == '0) ||
               (mag_w <= 32'(DEADBAND)) ||
               (dir_neg == cur_neg);
    hold     = (ldn < cur_mag) ? ldn : cur_mag;
    nmag     = lup;
    nneg     = dir_neg;
    if (same_dir) begin
      if (lup < cur_mag)
        nmag = (lup > hold) ? lup : hold;
      nneg = (cur_mag == '0) ? dir_neg : cur_neg;
    end
    new_lvl = nneg ? -$signed(LW'(nmag))
                   : $signed(LW'(nmag));
    pat = '0;
    for (int j = 0; j < HALF; j++) begin
      if (CW'(j) < nmag) begin
        if (nneg) pat[HALF-1-j] = 1'b1;
        else      pat[HALF+j]   = 1'b1;
      end
    end
    if (nmag == '0) pat = NEUTRAL;
  end

  // Calibrate / run state machine and register updates.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    center_d = center_q;
    led_d    = led_q;
    busy_d   = busy_q;
    level_d  = level_q;
    case (state_q)
      S_CAL: begin
        led_d = '0;
        if (cal_start) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (adc_valid) begin
          if (&cnt_q) begin
            center_d = ADC_W'(sum >> AVG_LOG2);
            level_d  = '0;
            led_d    = NEUTRAL;
            busy_d   = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_RUN;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + AVG_LOG2'(1);
          end
        end
      end
      S_RUN: begin
        if (cal_start) begin
          state_d = S_CAL;
          acc_d   = '0;
          cnt_d   = '0;
          led_d   = '0;
          busy_d  = 1'b1;
          level_d = '0;
        end else if (adc_valid) begin
          level_d = new_lvl;
          led_d   = pat;
        end
      end
      default: state_d = S_CAL;
    endcase
  end

  // State registers with synchronous reset into calibration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CAL;
      acc_q    <= '0;
      cnt_q    <= '0;
      center_q <= MID;
      led_q    <= '0;
      busy_q   <= 1'b1;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      center_q <= center_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      level_q  <= level_d;
    end
  end

  assign led_out  = led_q;
  assign center   = center_q;
  assign cal_busy = busy_q;
  assign level    = level_q;

endmodule

// File: tb/tb_adc_joystick_bargraph.sv
// Scoreboard bench for adc_joystick_bargraph.
// Directed samples; monitor checks one cycle after each valid.
module tb_adc_joystick_bargraph;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic        cal_start = 1'b0;
  logic [7:0]  led_out;
  logic [11:0] center;
  logic        cal_busy;
  logic [3:0]  level;

  adc_joystick_bargraph dut (
    .clk       (clk),
    .rst       (rst),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .cal_start (cal_start),
    .led_out   (led_out),
    .center    (center),
    .cal_busy  (cal_busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  led;
    logic [3:0]  lvl;
    logic [11:0] ctr;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic vld_q = 1'b0;

  always @(posedge clk) vld_q <= adc_valid;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_now(input string nm,
                         input logic [7:0] led,
                         input logic [3:0] lv,
                         input logic [11:0] c,
                         input logic b);
    chk({nm, ".led"}, 32'(led_out), 32'(led));
    chk({nm, ".lvl"}, 32'(level), 32'(lv));
    chk({nm, ".ctr"}, 32'(center), 32'(c));
    chk({nm, ".busy"}, 32'(cal_busy), 32'(b));
  endtask

  // Monitor: one output per accepted valid, next negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_q === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output t=%0t", $time);
        end else begin
          e = q.pop_front();
          chk_now("out", e.led, e.lvl, e.ctr, e.busy);
        end
      end
    end
  end

  task automatic smp(input logic [11:0] a,
                     input logic [7:0] led,
                     input logic [3:0] lv,
                     input logic [11:0] c,
                     input logic b,
                     input int gap);
    exp_t e;
    @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = a;
    e = {led, lv, c, b};
    q.push_back(e);
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic calv(input logic [11:0] a,
                      input logic [11:0] c);
    exp_t e;
    @(negedge clk);
    adc_valid = 1'b1;
    cal_start = 1'b1;
    adc_data  = a;
    e = {8'h00, 4'h0, c, 1'b1};
    q.push_back(e);
    @(negedge clk);
    adc_valid = 1'b0;
    cal_start = 1'b0;
  endtask

  task automatic calreq();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cal8(input logic [11:0] a,
                      input logic [11:0] old_c,
                      input logic [11:0] new_c);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) smp(a, 8'h18, 4'h0, new_c, 1'b0, 2);
      else        smp(a, 8'h00, 4'h0, old_c, 1'b1, 2);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_now("reset", 8'h00, 4'h0, 12'h800, 1'b1);

    cal8(12'd2048, 12'd2048, 12'd2048);

    smp(12'd2748, 8'h30, 4'h2, 12'd2048, 1'b0, 1);
    smp(12'd2048, 8'h18, 4'h0, 12'd2048, 1'b0, 0);
    smp(12'd2748, 8'h30, 4'h2, 12'd2048, 1'b0, 0);
    smp(12'd2658, 8'h30, 4'h2, 12'd2048, 1'b0, 0);
    smp(12'd2638, 8'h10, 4'h1, 12'd2048, 1'b0, 0);
    smp(12'd3248, 8'h70, 4'h3, 12'd2048, 1'b0, 0);
    smp(12'd348,  8'h0F, 4'hC, 12'd2048, 1'b0, 0);
    smp(12'd4095, 8'hF0, 4'h4, 12'd2048, 1'b0, 0);
    smp(12'd0,    8'h0F, 4'hC, 12'd2048, 1'b0, 1);

    calreq();
    chk_now("calreq", 8'h00, 4'h0, 12'd2048, 1'b1);

    for (int i = 0; i < 3; i++)
      smp(12'd1966, 8'h00, 4'h0, 12'd2048, 1'b1, 1);
    calv(12'd4095, 12'd2048);
    for (int i = 0; i < 4; i++)
      smp(12'd1966, 8'h00, 4'h0, 12'd2048, 1'b1, 0);
    for (int i = 0; i < 3; i++)
      smp(12'd1974, 8'h00, 4'h0, 12'd2048, 1'b1, 0);
    smp(12'd1974, 8'h18, 4'h0, 12'd1970, 1'b0, 1);

    smp(12'd1270, 8'h0C, 4'hE, 12'd1970, 1'b0, 2);

    do_rst();
    chk_now("rst_run", 8'h00, 4'h0, 12'h800, 1'b1);

    for (int i = 0; i < 3; i++)
      smp(12'd1000, 8'h00, 4'h0, 12'd2048, 1'b1, 0);
    do_rst();
    chk_now("rst_cal", 8'h00, 4'h0, 12'h800, 1'b1);
    repeat (4) @(negedge clk);
    chk_now("idle", 8'h00, 4'h0, 12'h800, 1'b1);

    cal8(12'd2048, 12'd2048, 12'd2048);
    repeat (3) @(negedge clk);
    chk_now("idle_run", 8'h18, 4'h0, 12'd2048, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_joystick_bargraph.md
Name: adc_joystick_bargraph

Overview:
Parametrised joystick-axis-to-LED bargraph, the successor to the fixed-threshold single-axis LED display. It self-calibrates the neutral centre by averaging ADC samples after reset or on request. It then maps the signed deflection from that centre to a centred LED bargraph, with a configurable dead-band, step size and hysteresis. It sits between the ADC sample interface and the board LEDs.

Parameters:
ADC_W, 12, ADC sample width in bits
N_LED, 8, LED count; even, >= 4; HALF = N_LED/2
AVG_LOG2, 3, calibration averages 2^AVG_LOG2 samples
DEADBAND, 125, |deflection| <= DEADBAND is neutral
STEP, 500, spacing between successive level thresholds
HYST, 32, hysteresis applied on falling level; HYST < STEP, HYST <= DEADBAND

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
adc_valid  in  1  one-cycle strobe: adc_data holds a new sample
adc_data  in  ADC_W  unsigned ADC conversion result
cal_start  in  1  one-cycle request to recalibrate the centre
led_out  out  N_LED  bargraph pattern, registered
center  out  ADC_W  current calibrated centre, registered
cal_busy  out  1  high while in CAL state
level  out  $clog2(HALF+1)+1  signed current level, two's complement, range -HALF..+HALF

Behaviour:
- Reset values: state=CAL, led_out=0, center=2^(ADC_W-1), cal_busy=1, level=0, accumulator=0, sample count=0.
- States: CAL and RUN. Reset mid-operation always returns to CAL with the reset values above.
- CAL state:
  - On each adc_valid: acc += adc_data (acc is ADC_W+AVG_LOG2 bits, no overflow possible); cnt++.
  - When the 2^AVG_LOG2-th sample is accepted: center <= (acc + that sample) >> AVG_LOG2 (truncate); level <= 0; led_out <= neutral pattern; cal_busy <= 0; go to RUN.
  - led_out = 0 throughout CAL.
  - cal_start in CAL: clear acc and cnt. The sample in that same cycle is discarded.
- RUN state, on adc_valid:
  - d = adc_data - center, signed ADC_W+1 bits; m = |d|, fits in ADC_W bits.
  - Thresholds T_k = DEADBAND + (k-1)*STEP for k = 1..HALF, computed wide enough that they cannot overflow.
  - Lup = number of k with m > T_k.
  - Ldn = number of k with m > max(T_k - HYST, 0).
  - Direction: dir = sign of d. Direction is irrelevant when m <= DEADBAND.
  - Level update:
    - If the current level is 0, or dir equals the current sign: new |level| = Lup if Lup >= |level|, else max(Lup, min(Ldn, |level|)).
    - If dir differs from the current sign and Lup > 0: level <= Lup with the new sign; no hysteresis.
    - If dir differs from the current sign and Lup = 0: level <= 0.
  - led_out is registered in the same edge as level; latency is 1 cycle from the adc_valid cycle.
- adc_valid low: all registers hold.
- cal_start in RUN: go to CAL; clear acc/cnt; led_out <= 0; cal_busy <= 1; level <= 0; center holds its old value until the new calibration completes. cal_start has priority over a coincident adc_valid.
- Display mapping:
  - level 0: led_out[HALF-1] and led_out[HALF] set, all others 0.
  - level +k: led_out[HALF+j] = 1 for j < k, others 0.
  - level -k: led_out[HALF-1-j] = 1 for j < k, others 0.
- Boundaries:
  - adc_data = 0 or full-scale saturates at |level| = HALF.
  - Thresholds beyond the ADC range are simply unreachable.
  - A centre near a rail gives an asymmetric reach; this is acceptable.

Test Plan:
- Reset, then 8 samples of 2048 with gaps between valids -> cal_busy falls after the 8th sample; center=2048; led_out=00011000.
- Calibrate with 4x1966 then 4x1974 -> center=1970. A cal_start asserted after 3 samples restarts the count, so 8 further samples are needed.
- center=2048; adc=2748 (m=700) -> led_out=00110000, level=+2 one cycle later; adc=2048 -> 00011000.
- Hysteresis, center=2048, level=+2: adc=2658 (m=610 > 593) -> level stays +2; adc=2638 (m=590) -> level +1, led_out=00010000.
- Direction flip: from level +3, adc=348 (m=1700) -> level -4, led_out=00001111 directly. adc=4095 -> level +4, led_out=11110000.
- rst asserted mid-RUN and mid-CAL -> all outputs at reset values the next cycle. The next 8 samples recalibrate; outputs are unaffected while adc_valid is low.
